writeback_trap: RTL and testbench

WRITEBACK_TRAP -- requirements
Module: writeback_trap

---
 rtl/writeback_trap.sv | 196 +++++++++++++++++++
 tb/tb_writeback_trap.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_trap.sv
// writeback_trap -- writeback stage with trap/interrupt resolution and an
// optional wait-for-interrupt sleep state.
//
// An instruction offered on valid_in is accepted when ready_out is high. One
// cycle later it either retires (register-file write, mret pulse, instret
// increment) or traps (traped pulse, cause/interupt/ecp updated, no write).
// Pending interrupts (irq gated by irq_enable) win over exception_in; among
// interrupt lines the highest set index wins, its cause taken from IRQ_CAUSE.
//
// Optional feature macro: WB_WFI_EN
//   defined   : a retired wfi_in enters SLEEP (ready_out low) and latches
//               next_pc; any irq bit wakes it, trapping to the latched
//               next_pc when irq_enable is high.
//   undefined : wfi_in retires as a no-write nop; ready_out is tied high.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   valid_in / ready_out  instruction handshake
//   pc, next_pc           instruction address and its successor
//   alu_data, csr_data,
//   load_data             result sources chosen by write_select
//   write_select          0=ALU, 1=CSR, 2=LOAD, 3=NEXT_PC
//   rd_addr_in            destination register (x0 never written)
//   mret_in, wfi_in       instruction kind flags
//   exception_in/ecause_in synchronous exception and its cause
//   irq, irq_enable       pending interrupt lines, global enable
//   rd_we/rd_addr_out/rd_data  register-file write (rd_we is a pulse)
//   traped                trap pulse; ecause/interupt/ecp hold last trap
//   mret_out              mret retirement pulse
//   instret               retired instruction counter (wraps)
//
// rd_addr_out and rd_data are refreshed on every retirement, including ones
// that do not write (rd=x0 or wfi), and hold otherwise.
module writeback_trap #(
  parameter int                     XLEN      = 32,
  parameter int                     NUM_IRQ   = 3,
  parameter logic [4*NUM_IRQ-1:0]   IRQ_CAUSE = 12'hB73
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    next_pc,
  input  logic [XLEN-1:0]    alu_data,
  input  logic [XLEN-1:0]    csr_data,
  input  logic [XLEN-1:0]    load_data,
  input  logic [1:0]         write_select,
  input  logic [4:0]         rd_addr_in,
  input  logic               mret_in,
  input  logic               wfi_in,
  input  logic               exception_in,
  input  logic [3:0]         ecause_in,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_enable,
  output logic               rd_we,
  output logic [4:0]         rd_addr_out,
  output logic [XLEN-1:0]    rd_data,
  output logic               traped,
  output logic [3:0]         ecause,
  output logic               interupt,
  output logic [XLEN-1:0]    ecp,
  output logic               mret_out,
  output logic [63:0]        instret
);

  localparam logic [1:0] WRITE_SEL_ALU     = 2'd0;
  localparam logic [1:0] WRITE_SEL_CSR     = 2'd1;
  localparam logic [1:0] WRITE_SEL_LOAD    = 2'd2;
  localparam logic [1:0] WRITE_SEL_NEXT_PC = 2'd3;

  logic            int_req_s;
  logic            accept_s;
  logic            trap_s;
  logic            retire_s;
  logic            wake_trap_s;
  logic [3:0]      irq_cause_s;
  logic [XLEN-1:0] wb_data_s;
  logic [XLEN-1:0] wake_pc_s;

  // Accept/trap/retire decode for the instruction on the handshake.
  always_comb begin
    int_req_s = irq_enable && (|irq);
    accept_s  = valid_in && ready_out;
    trap_s    = accept_s && (exception_in || int_req_s);
    retire_s  = accept_s && !(exception_in || int_req_s);
  end

  // Cause of the highest-index pending line; later iterations override earlier.
  always_comb begin
    irq_cause_s = 4'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irq_cause_s = irq[i] ? IRQ_CAUSE[4*i +: 4] : irq_cause_s;
    end
  end

  // Writeback result mux.
  always_comb begin
    wb_data_s = {XLEN{1'b0}};
    case (write_select)
      WRITE_SEL_ALU:     wb_data_s = alu_data;
      WRITE_SEL_CSR:     wb_data_s = csr_data;
      WRITE_SEL_LOAD:    wb_data_s = load_data;
      WRITE_SEL_NEXT_PC: wb_data_s = next_pc;
      default:           wb_data_s = {XLEN{1'b0}};
    endcase
  end

`ifdef WB_WFI_EN
  typedef enum logic [0:0] {RUN = 1'b0, SLEEP = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] wake_pc_r;

  assign ready_out = (state_r == RUN);
  assign wake_pc_s = wake_pc_r;

  // Sleep FSM next state; a wake traps only when interrupts are enabled.
  always_comb begin
    state_nxt_s = state_r;
    wake_trap_s = 1'b0;
    case (state_r)
      RUN: begin
        if (retire_s && wfi_in) state_nxt_s = SLEEP;
        else                    state_nxt_s = RUN;
      end
      SLEEP: begin
        if (|irq) begin
          state_nxt_s = RUN;
          wake_trap_s = irq_enable;
        end else begin
          state_nxt_s = SLEEP;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Sleep FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= RUN;
    else       state_r <= state_nxt_s;
  end

  // Resume address captured when a wfi retires.
  always_ff @(posedge clk) begin
    if (reset)                      wake_pc_r <= {XLEN{1'b0}};
    else if (retire_s && wfi_in)    wake_pc_r <= next_pc;
    else                            wake_pc_r <= wake_pc_r;
  end
`else
  assign ready_out   = 1'b1;
  assign wake_trap_s = 1'b0;
  assign wake_pc_s   = {XLEN{1'b0}};
`endif

  // Registered outputs; pulses clear every cycle, trap info holds until the next trap.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_we       <= 1'b0;
      rd_addr_out <= 5'd0;
      rd_data     <= {XLEN{1'b0}};
      traped      <= 1'b0;
      ecause      <= 4'd0;
      interupt    <= 1'b0;
      ecp         <= {XLEN{1'b0}};
      mret_out    <= 1'b0;
      instret     <= 64'd0;
    end else begin
      rd_we    <= 1'b0;
      traped   <= 1'b0;
      mret_out <= 1'b0;
      if (trap_s) begin
        traped   <= 1'b1;
        ecause   <= int_req_s ? irq_cause_s : ecause_in;
        interupt <= int_req_s;
        ecp      <= pc;
      end else if (wake_trap_s) begin
        traped   <= 1'b1;
        ecause   <= irq_cause_s;
        interupt <= 1'b1;
        ecp      <= wake_pc_s;
      end else if (retire_s) begin
        rd_we       <= (rd_addr_in != 5'd0) && !wfi_in;
        rd_addr_out <= rd_addr_in;
        rd_data     <= wb_data_s;
        mret_out    <= mret_in;
        instret     <= instret + 64'd1;
      end else begin
        instret <= instret;
      end
    end
  end

endmodule

// File: tb/tb_writeback_trap.sv
module tb_writeback_trap;

  localparam int XLEN = 32;
`ifdef WB_WFI_EN
  localparam bit WFI_EN = 1'b1;
`else
  localparam bit WFI_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_in;
  logic            ready_out;
  logic [XLEN-1:0] pc, next_pc, alu_data, csr_data, load_data;
  logic [1:0]      write_select;
  logic [4:0]      rd_addr_in;
  logic            mret_in, wfi_in, exception_in;
  logic [3:0]      ecause_in;
  logic [2:0]      irq;
  logic            irq_enable;
  logic            rd_we;
  logic [4:0]      rd_addr_out;
  logic [XLEN-1:0] rd_data;
  logic            traped;
  logic [3:0]      ecause;
  logic            interupt;
  logic [XLEN-1:0] ecp;
  logic            mret_out;
  logic [63:0]     instret;

  writeback_trap dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .pc(pc), .next_pc(next_pc), .alu_data(alu_data), .csr_data(csr_data),
    .load_data(load_data), .write_select(write_select), .rd_addr_in(rd_addr_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .exception_in(exception_in),
    .ecause_in(ecause_in), .irq(irq), .irq_enable(irq_enable),
    .rd_we(rd_we), .rd_addr_out(rd_addr_out), .rd_data(rd_data),
    .traped(traped), .ecause(ecause), .interupt(interupt), .ecp(ecp),
    .mret_out(mret_out), .instret(instret)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic [11:0]     cause_tab = 12'hB73;
  bit              m_sleep;
  logic [XLEN-1:0] m_wake_pc;
  logic            m_rd_we, m_traped, m_interupt, m_mret;
  logic [4:0]      m_rd_addr;
  logic [XLEN-1:0] m_rd_data, m_ecp;
  logic [3:0]      m_ecause;
  logic [63:0]     m_instret;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] top_irq_cause(input logic [2:0] lines);
    logic [3:0] c = 4'd0;
    for (int i = 2; i >= 0; i--) begin
      if (lines[i]) begin
        c = cause_tab[4*i +: 4];
        break;
      end
    end
    return c;
  endfunction

  function automatic logic [XLEN-1:0] pick_data(input logic [1:0] sel);
    case (sel)
      2'd0:    return alu_data;
      2'd1:    return csr_data;
      2'd2:    return load_data;
      default: return next_pc;
    endcase
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit want_irq;
    m_rd_we = 1'b0; m_traped = 1'b0; m_mret = 1'b0;
    want_irq = irq_enable && (irq != 3'b000);
    if (reset) begin
      m_sleep = 1'b0; m_wake_pc = '0; m_rd_addr = 5'd0; m_rd_data = '0;
      m_ecause = 4'd0; m_interupt = 1'b0; m_ecp = '0; m_instret = 64'd0;
    end else if (m_sleep) begin
      if (irq != 3'b000) begin
        m_sleep = 1'b0;
        if (irq_enable) begin
          m_traped = 1'b1; m_ecause = top_irq_cause(irq);
          m_interupt = 1'b1; m_ecp = m_wake_pc;
        end
      end
    end else if (valid_in) begin
      if (want_irq) begin
        m_traped = 1'b1; m_ecause = top_irq_cause(irq); m_interupt = 1'b1; m_ecp = pc;
      end else if (exception_in) begin
        m_traped = 1'b1; m_ecause = ecause_in; m_interupt = 1'b0; m_ecp = pc;
      end else begin
        m_instret = m_instret + 64'd1;
        m_rd_addr = rd_addr_in;
        m_rd_data = pick_data(write_select);
        m_rd_we   = (rd_addr_in != 5'd0) && !wfi_in;
        m_mret    = mret_in;
        if (WFI_EN && wfi_in) begin
          m_sleep = 1'b1; m_wake_pc = next_pc;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ready_out",   ready_out,   !m_sleep);
    chk("rd_we",       rd_we,       m_rd_we);
    chk("rd_addr_out", rd_addr_out, m_rd_addr);
    chk("rd_data",     rd_data,     m_rd_data);
    chk("traped",      traped,      m_traped);
    chk("ecause",      ecause,      m_ecause);
    chk("interupt",    interupt,    m_interupt);
    chk("ecp",         ecp,         m_ecp);
    chk("mret_out",    mret_out,    m_mret);
    chk("instret",     instret,     m_instret);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; pc = '0; next_pc = '0; alu_data = '0; csr_data = '0;
    load_data = '0; write_select = 2'd0; rd_addr_in = 5'd0; mret_in = 1'b0;
    wfi_in = 1'b0; exception_in = 1'b0; ecause_in = 4'd0; irq = 3'b000;
    irq_enable = 1'b0;
  endtask

  task automatic rand_inputs();
    reset        = ($urandom_range(0, 59) == 0);
    valid_in     = ($urandom_range(0, 3) != 0);
    pc           = $urandom;
    next_pc      = $urandom;
    alu_data     = $urandom;
    csr_data     = $urandom;
    load_data    = $urandom;
    write_select = 2'($urandom_range(0, 3));
    rd_addr_in   = 5'($urandom_range(0, 31));
    mret_in      = ($urandom_range(0, 7) == 0);
    wfi_in       = ($urandom_range(0, 5) == 0);
    exception_in = ($urandom_range(0, 7) == 0);
    ecause_in    = 4'($urandom_range(0, 15));
    irq          = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    irq_enable   = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    idle_inputs();
    m_sleep = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("reset_instret", instret, 64'd0);
    chk("reset_ready", ready_out, 1'b1);
    reset = 1'b0;

    // Plain ALU write to x5
    valid_in = 1'b1; pc = 32'h100; write_select = 2'd0; alu_data = 32'h55; rd_addr_in = 5'd5;
    tick();
    chk("alu_rd_we", rd_we, 1'b1);
    chk("alu_rd_addr", rd_addr_out, 5'd5);
    chk("alu_rd_data", rd_data, 32'h55);
    chk("alu_instret", instret, 64'd1);

    // Interrupt beats exception; highest line 2 -> cause 11
    idle_inputs();
    valid_in = 1'b1; pc = 32'h200; irq = 3'b101; irq_enable = 1'b1;
    exception_in = 1'b1; ecause_in = 4'd2; rd_addr_in = 5'd9;
    tick();
    chk("prio_traped", traped, 1'b1);
    chk("prio_ecause", ecause, 4'd11);
    chk("prio_interupt", interupt, 1'b1);
    chk("prio_ecp", ecp, 32'h200);
    chk("prio_rd_we", rd_we, 1'b0);

    // Trap info holds while idle; irq with valid low takes nothing
    idle_inputs();
    irq = 3'b010; irq_enable = 1'b1;
    tick();
    chk("hold_ecause", ecause, 4'd11);

    // Load to x0: no write, still retires
    idle_inputs();
    valid_in = 1'b1; write_select = 2'd2; load_data = 32'hDEAD; rd_addr_in = 5'd0;
    tick();
    chk("x0_rd_we", rd_we, 1'b0);
    chk("x0_instret", instret, 64'd2);

    if (WFI_EN) begin
      // Sleep, wake with interrupts enabled
      idle_inputs();
      valid_in = 1'b1; wfi_in = 1'b1; next_pc = 32'h304; rd_addr_in = 5'd3;
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("sleep_ready", ready_out, 1'b0);
      end
      irq = 3'b010; irq_enable = 1'b1;
      tick();
      chk("wake_traped", traped, 1'b1);
      chk("wake_ecause", ecause, 4'd7);
      chk("wake_ecp", ecp, 32'h304);
      idle_inputs();
      tick();

      // Sleep, wake with interrupts disabled
      valid_in = 1'b1; wfi_in = 1'b1; next_pc = 32'h404;
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) tick();
      irq = 3'b010; irq_enable = 1'b0;
      tick();
      chk("wake_noen_traped", traped, 1'b0);
      chk("wake_noen_ready", ready_out, 1'b1);
      idle_inputs();
      tick();

      // Reset in the same cycle as a wake
      valid_in = 1'b1; wfi_in = 1'b1; next_pc = 32'h504;
      tick();
      idle_inputs();
      tick();
      reset = 1'b1; irq = 3'b001; irq_enable = 1'b1;
      tick();
      chk("rst_sleep_ready", ready_out, 1'b1);
      chk("rst_sleep_instret", instret, 64'd0);
      chk("rst_sleep_traped", traped, 1'b0);
      reset = 1'b0;
      idle_inputs();
      tick();
    end

    // Counter wrap from all-ones
    idle_inputs();
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    valid_in = 1'b1; mret_in = 1'b1; rd_addr_in = 5'd1; write_select = 2'd3; next_pc = 32'h44;
    tick();
    chk("wrap_instret", instret, 64'd0);
    chk("wrap_mret", mret_out, 1'b1);
    idle_inputs();
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
